// File: rtl/bus_tx_fifo_if.sv
// bus_tx_fifo_if: device push, bus pop and status signals of one transmit queue
interface bus_tx_fifo_if #(
    parameter int pckg_sz = 16,
    parameter int depth   = 8
);
    logic                    push_in;
    logic [pckg_sz-1:0]      D_in;
    logic                    full;
    logic                    pndng;
    logic                    pop;
    logic [pckg_sz-1:0]      D_pop;
    logic [$clog2(depth):0]  count;
    logic                    ovf;
    logic                    self_err;
    logic [15:0]             tx_cnt;
    logic [15:0]             drop_cnt;
    modport slave (
        input  push_in, D_in, pop,
        output full, pndng, D_pop, count, ovf, self_err, tx_cnt, drop_cnt
    );
    modport master (
        output push_in, D_in, pop,
        input  full, pndng, D_pop, count, ovf, self_err, tx_cnt, drop_cnt
    );
endinterface

// File: rtl/bus_tx_fifo.sv
// bus_tx_fifo: per-device transmit queue feeding one bus port; optional counters under BUS_TX_FIFO_STATS_EN
module bus_tx_fifo #(
    parameter int         pckg_sz = 16,
    parameter int         depth   = 8,
    parameter logic [7:0] ID      = 8'd0
) (
    input logic          clk,
    input logic          reset,
    bus_tx_fifo_if.slave bus
);
    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;
    logic [pckg_sz-1:0] mem_q [depth];
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               ovf_q, ovf_d, self_err_q, self_err_d;
    logic               self_hit, full_w, do_push, do_pop, full_drop;
    // Classify this cycle's push/pop and compute next pointers, occupancy and flags
    always_comb begin
        self_hit   = bus.push_in && (bus.D_in[pckg_sz-1 -: 8] == ID);
        full_w     = count_q == CW'(depth);
        do_pop     = bus.pop && (count_q != '0);
        do_push    = bus.push_in && !self_hit && (!full_w || bus.pop);
        full_drop  = bus.push_in && !self_hit && full_w && !bus.pop;
        wr_ptr_d   = wr_ptr_q + AW'(do_push);
        rd_ptr_d   = rd_ptr_q + AW'(do_pop);
        count_d    = count_q + CW'(do_push) - CW'(do_pop);
        ovf_d      = ovf_q || full_drop;
        self_err_d = self_hit;
    end
    // Pointer, occupancy and flag registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            self_err_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            self_err_q <= self_err_d;
        end
    end
    // Storage needs no reset: entries are only visible once counted
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= bus.D_in;
    end
    assign bus.count    = count_q;
    assign bus.pndng    = count_q != '0;
    assign bus.full     = full_w;
    assign bus.D_pop    = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign bus.ovf      = ovf_q;
    assign bus.self_err = self_err_q;
`ifdef BUS_TX_FIFO_STATS_EN
    logic [15:0] tx_q, tx_d, drop_q, drop_d;
    // Saturating pop and drop counters
    always_comb begin
        tx_d   = (do_pop && tx_q != 16'hFFFF) ? tx_q + 16'd1 : tx_q;
        drop_d = ((self_hit || full_drop) && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    end
    // Counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_q   <= '0;
            drop_q <= '0;
        end else begin
            tx_q   <= tx_d;
            drop_q <= drop_d;
        end
    end
    assign bus.tx_cnt   = tx_q;
    assign bus.drop_cnt = drop_q;
`else
    assign bus.tx_cnt   = '0;
    assign bus.drop_cnt = '0;
`endif
endmodule

// File: tb/tb_bus_tx_fifo.sv
// tb_bus_tx_fifo: queue-model bench for bus_tx_fifo (pckg_sz=16, depth=8, ID=2)
module tb_bus_tx_fifo;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;
    bit   chk_en = 1'b0;
    logic [15:0] mq [$];
    bit          m_ovf = 1'b0;
    bit          m_self = 1'b0;
    int          m_tx = 0;
    int          m_drop = 0;

    bus_tx_fifo_if #(.pckg_sz(16), .depth(8)) bus ();
    bus_tx_fifo #(.pckg_sz(16), .depth(8), .ID(8'd2)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step(input logic p, input logic [15:0] d, input logic q);
        bus.push_in = p;
        bus.D_in    = d;
        bus.pop     = q;
        @(negedge clk);
    endtask

    // Reference: a packet queue plus flags, updated from the inputs seen at each rising edge
    always @(posedge clk) begin : model
        bit sh, acc, pv;
        if (!reset) begin
            sh  = bus.push_in && bus.D_in[15:8] == 8'd2;
            pv  = bus.pop && mq.size() > 0;
            acc = bus.push_in && !sh && (mq.size() < 8 || bus.pop);
            if (bus.push_in && !sh && !acc) begin
                m_ovf = 1'b1;
                if (m_drop < 65535) m_drop++;
            end
            if (sh && m_drop < 65535) m_drop++;
            m_self = sh;
            if (pv) begin
                void'(mq.pop_front());
                if (m_tx < 65535) m_tx++;
            end
            if (acc) mq.push_back(bus.D_in);
        end
    end

    // Compare every output against the model once per cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("count", 32'(bus.count), 32'(mq.size()));
            chk("pndng", 32'(bus.pndng), 32'(mq.size() != 0));
            chk("full", 32'(bus.full), 32'(mq.size() == 8));
            chk("D_pop", 32'(bus.D_pop), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
            chk("ovf", 32'(bus.ovf), 32'(m_ovf));
            chk("self_err", 32'(bus.self_err), 32'(m_self));
`ifdef BUS_TX_FIFO_STATS_EN
            chk("tx_cnt", 32'(bus.tx_cnt), 32'(m_tx));
            chk("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
`else
            chk("tx_cnt", 32'(bus.tx_cnt), 32'd0);
            chk("drop_cnt", 32'(bus.drop_cnt), 32'd0);
`endif
        end
    end

    initial begin
        bus.push_in = 1'b0;
        bus.D_in    = '0;
        bus.pop     = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_pndng", 32'(bus.pndng), 32'd0);
        chk("rst_dpop", 32'(bus.D_pop), 32'd0);
        reset  = 1'b0;
        chk_en = 1'b1;
        // single packet round trip
        step(1, 16'h05AA, 0);
        chk("t1_pndng", 32'(bus.pndng), 32'd1);
        chk("t1_dpop", 32'(bus.D_pop), 32'h05AA);
        chk("t1_count", 32'(bus.count), 32'd1);
        step(0, 16'h0, 1);
        chk("t1_empty_pndng", 32'(bus.pndng), 32'd0);
        chk("t1_empty_dpop", 32'(bus.D_pop), 32'd0);
        // self-addressed push is rejected without touching ovf
        step(1, 16'h02FF, 0);
        chk("t3_self_err", 32'(bus.self_err), 32'd1);
        chk("t3_count", 32'(bus.count), 32'd0);
        chk("t3_ovf", 32'(bus.ovf), 32'd0);
        step(0, 16'h0, 0);
        chk("t3_self_pulse", 32'(bus.self_err), 32'd0);
        // fill, overflow drop, drain in order
        for (int i = 0; i < 8; i++) step(1, 16'h0100 + 16'(i), 0);
        chk("t2_full", 32'(bus.full), 32'd1);
        chk("t2_count", 32'(bus.count), 32'd8);
        chk("t2_model", 32'(mq.size()), 32'd8);
        step(1, 16'h0108, 0);
        chk("t2_ovf", 32'(bus.ovf), 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk("t2_order", 32'(bus.D_pop), 32'h0100 + 32'(i));
            step(0, 16'h0, 1);
        end
        chk("t2_drained", 32'(bus.count), 32'd0);
        // push while full with a same-cycle pop
        for (int i = 0; i < 8; i++) step(1, 16'h0300 + 16'(i), 0);
        step(1, 16'h0309, 1);
        chk("t4_count", 32'(bus.count), 32'd8);
        chk("t4_full", 32'(bus.full), 32'd1);
        chk("t4_head", 32'(bus.D_pop), 32'h0301);
        for (int i = 0; i < 7; i++) step(0, 16'h0, 1);
        chk("t4_last", 32'(bus.D_pop), 32'h0309);
        step(0, 16'h0, 1);
`ifdef BUS_TX_FIFO_STATS_EN
        chk("stats_tx", 32'(bus.tx_cnt), 32'd18);
        chk("stats_drop", 32'(bus.drop_cnt), 32'd2);
`endif
        // streaming push+pop so both pointers wrap, then pop on empty
        for (int i = 0; i < 20; i++) step(1, 16'h0400 + 16'(i), 1);
        chk("t5_count", 32'(bus.count), 32'd1);
        chk("t5_head", 32'(bus.D_pop), 32'h0413);
        step(0, 16'h0, 1);
        step(0, 16'h0, 1);
        chk("t5_empty_pop", 32'(bus.count), 32'd0);
        // randomized traffic with destinations around ID
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 9) < 6), {8'($urandom_range(1, 3)), 8'($urandom)},
                 1'($urandom_range(0, 1)));
        // asynchronous reset with entries queued
        for (int i = 0; i < 9; i++) step(0, 16'h0, 1);
        for (int i = 0; i < 5; i++) step(1, 16'h0500 + 16'(i), 0);
        chk("t6_count_before", 32'(bus.count), 32'd5);
        #2;
        reset = 1'b1;
        mq.delete();
        m_ovf = 1'b0; m_self = 1'b0; m_tx = 0; m_drop = 0;
        #1;
        chk("t6_pndng", 32'(bus.pndng), 32'd0);
        chk("t6_count", 32'(bus.count), 32'd0);
        chk("t6_ovf", 32'(bus.ovf), 32'd0);
        chk("t6_dpop", 32'(bus.D_pop), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step(1, 16'h0777, 0);
        chk("t6_after", 32'(bus.D_pop), 32'h0777);
        step(0, 16'h0, 0);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
